// File: rtl/muller_c_pkg.sv
// Shared types for the Muller C-element protocol monitor.
package muller_c_pkg;

  // Observer FSM states. The encodings are visible on state_o.
  typedef enum logic [2:0] {
    INIT     = 3'd0,
    LOW      = 3'd1,
    ARMED_HI = 3'd2,
    HIGH     = 3'd3,
    ARMED_LO = 3'd4,
    ERR      = 3'd5
  } state_e;

  // First-cause error codes.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_SPURIOUS = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // True for the two states where the C-element is expected to switch.
  function automatic logic is_armed(input state_e s);
    return (s == ARMED_HI) || (s == ARMED_LO);
  endfunction

endpackage

// File: rtl/muller_c_sync.sv
// Single-bit multi-flop synchroniser with synchronous active-low reset to 0.
module muller_c_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_chain <= '0;
    else            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/muller_c_monitor.sv
// Clocked observer of a Muller C-element: synchronises a, b, c, tracks the
// 4-phase protocol, counts completed c cycles and latches the first error.
module muller_c_monitor
  import muller_c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_async,
  input  logic             b_async,
  input  logic             c_async,
  input  logic             clear,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [2:0]       state_o,
  output logic             busy
);

  // INIT waits until the synchroniser chains carry post-reset samples.
  localparam int IW = $clog2(SYNC_STAGES + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic w_a_s, w_b_s, w_c_s;

  muller_c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .i_clock(clock), .i_reset_n(reset_n), .i_d(a_async), .o_q(w_a_s));
  muller_c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .i_clock(clock), .i_reset_n(reset_n), .i_d(b_async), .o_q(w_b_s));
  muller_c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c (
    .i_clock(clock), .i_reset_n(reset_n), .i_d(c_async), .o_q(w_c_s));

  state_e           r_state;
  logic [IW-1:0]    r_init_cnt;
  logic [TW-1:0]    r_tcnt;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic [1:0]       r_code;
  logic             r_busy;

  state_e     w_nxt;
  logic       w_inc;
  logic       w_viol;
  logic [1:0] w_vcode;
  logic       w_ab, w_any, w_tmo;

  assign w_ab  = w_a_s & w_b_s;
  assign w_any = w_a_s | w_b_s;
  // Fires on the clock that would make the armed-state count reach TIMEOUT.
  assign w_tmo = (TIMEOUT > 0) && ((int'(r_tcnt) + 1) >= TIMEOUT);

  // Protocol rules: next state, cycle completion and violation detection.
  always_comb begin
    w_nxt   = r_state;
    w_inc   = 1'b0;
    w_viol  = 1'b0;
    w_vcode = ERR_NONE;
    case (r_state)
      INIT:
        if (r_init_cnt == IW'(SYNC_STAGES)) w_nxt = w_c_s ? HIGH : LOW;
      LOW:
        if (w_ab && w_c_s)  w_nxt = HIGH;      // c beat a/b through the syncs
        else if (w_ab)      w_nxt = ARMED_HI;
        else if (w_c_s)     begin w_viol = 1'b1; w_vcode = ERR_SPURIOUS; end
      ARMED_HI:
        if (w_c_s)          w_nxt = HIGH;
        else if (!w_ab)     w_nxt = LOW;       // inputs withdrawn, legal
        else if (w_tmo)     begin w_viol = 1'b1; w_vcode = ERR_TIMEOUT; end
      HIGH:
        if (!w_any && !w_c_s) begin w_nxt = LOW; w_inc = 1'b1; end
        else if (!w_any)      w_nxt = ARMED_LO;
        else if (!w_c_s)      begin w_viol = 1'b1; w_vcode = ERR_SPURIOUS; end
      ARMED_LO:
        if (!w_c_s)         begin w_nxt = LOW; w_inc = 1'b1; end
        else if (w_any)     w_nxt = HIGH;
        else if (w_tmo)     begin w_viol = 1'b1; w_vcode = ERR_TIMEOUT; end
      ERR:
        if (clear)          w_nxt = w_c_s ? HIGH : LOW;
      default:              w_nxt = INIT;
    endcase
    // A clear in the same cycle suppresses the error; the state holds.
    if (w_viol && !clear) w_nxt = ERR;
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_tcnt     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_code     <= ERR_NONE;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= is_armed(w_nxt);

      if (r_state == INIT) r_init_cnt <= r_init_cnt + IW'(1);

      if (TIMEOUT == 0)                                   r_tcnt <= '0;
      else if (is_armed(w_nxt) && (w_nxt != r_state))     r_tcnt <= '0;
      else if (is_armed(r_state) && (r_tcnt != TW'(TIMEOUT)))
                                                          r_tcnt <= r_tcnt + TW'(1);

      if (clear)      r_count <= '0;
      else if (w_inc) r_count <= r_count + CNT_W'(1);

      // Only the first cause is kept: ERR never re-detects.
      if (clear) begin
        r_err  <= 1'b0;
        r_code <= ERR_NONE;
      end else if (w_viol) begin
        r_err  <= 1'b1;
        r_code <= w_vcode;
      end
    end
  end

  assign cycle_count = r_count;
  assign err         = r_err;
  assign err_code    = r_code;
  assign state_o     = r_state;
  assign busy        = r_busy;

endmodule

// File: tb/tb_muller_c_monitor.sv
// Directed + random bench for muller_c_monitor, two instances (TIMEOUT 16 and 0)
// against a timestamp-based reference model of the protocol rules.
module tb_muller_c_monitor;

  localparam int S = 2;
  localparam int TOV [2] = '{16, 0};

  logic clock = 1'b0;
  logic reset_n, a, b, c, clr;

  logic [7:0] cnt16, cnt0;
  logic       err16, err0, busy16, busy0;
  logic [1:0] code16, code0;
  logic [2:0] st16, st0;

  always #5 clock = ~clock;

  muller_c_monitor #(.SYNC_STAGES(S), .CNT_W(8), .TIMEOUT(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .a_async(a), .b_async(b), .c_async(c),
    .clear(clr), .cycle_count(cnt16), .err(err16), .err_code(code16),
    .state_o(st16), .busy(busy16));

  muller_c_monitor #(.SYNC_STAGES(S), .CNT_W(8), .TIMEOUT(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .a_async(a), .b_async(b), .c_async(c),
    .clear(clr), .cycle_count(cnt0), .err(err0), .err_code(code0),
    .state_o(st0), .busy(busy0));

  int nvec = 0;
  int nerr = 0;

  // Reference model: synchronisers as a history queue, INIT and timeouts as
  // elapsed time since a timestamped event.
  logic [2:0] hist[$];
  int now = 0;
  int rel_at = 0;
  int m_st [2], m_cnt [2], m_err [2], m_code [2], m_ent [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] s;
    if (!reset_n) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_front(3'b000);
      rel_at = now;
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_code[k] = 0; m_ent[k] = 0;
      end
    end else begin
      s = hist[$];
      for (int k = 0; k < 2; k++) begin
        int  st, ns, vc;
        bit  inc, vio, ab, any, cs, tmo;
        st = m_st[k]; ns = st; vc = 0; inc = 0; vio = 0;
        ab = s[2] & s[1]; any = s[2] | s[1]; cs = s[0];
        tmo = (TOV[k] > 0) && ((now - m_ent[k]) >= TOV[k]);
        case (st)
          0: if (now - rel_at > S) ns = cs ? 3 : 1;
          1: if (ab && cs) ns = 3; else if (ab) ns = 2; else if (cs) begin vio = 1; vc = 1; end
          2: if (cs) ns = 3; else if (!ab) ns = 1; else if (tmo) begin vio = 1; vc = 2; end
          3: if (!any && !cs) begin ns = 1; inc = 1; end
             else if (!any) ns = 4; else if (!cs) begin vio = 1; vc = 1; end
          4: if (!cs) begin ns = 1; inc = 1; end
             else if (any) ns = 3; else if (tmo) begin vio = 1; vc = 2; end
          default: if (clr) ns = cs ? 3 : 1;
        endcase
        if (vio && !clr) ns = 5;
        if ((ns == 2 || ns == 4) && ns != st) m_ent[k] = now;
        if (clr) m_cnt[k] = 0; else if (inc) m_cnt[k] = (m_cnt[k] + 1) % 256;
        if (clr) begin m_err[k] = 0; m_code[k] = 0; end
        else if (vio) begin m_err[k] = 1; m_code[k] = vc; end
        m_st[k] = ns;
      end
      hist.push_front({a, b, c});
      void'(hist.pop_back());
    end
    now++;
  endtask

  // One clock: advance the model, let the DUTs clock, compare #1 later.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    chk("st16",   st16,   m_st[0]);
    chk("cnt16",  cnt16,  m_cnt[0]);
    chk("err16",  err16,  m_err[0]);
    chk("code16", code16, m_code[0]);
    chk("busy16", busy16, (m_st[0] == 2 || m_st[0] == 4));
    chk("st0",    st0,    m_st[1]);
    chk("cnt0",   cnt0,   m_cnt[1]);
    chk("err0",   err0,   m_err[1]);
    chk("code0",  code0,  m_code[1]);
    chk("busy0",  busy0,  (m_st[1] == 2 || m_st[1] == 4));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic handshake();
    a = 1; b = 1; steps(3);
    c = 1;        steps(3);
    a = 0; b = 0; steps(3);
    c = 0;        steps(3);
  endtask

  initial begin
    int armed_n, saved;
    reset_n = 0; a = 0; b = 0; c = 0; clr = 0;

    // Reset held 3 clocks.
    steps(3);
    chk("rst_state", st16, 0);
    chk("rst_cnt", cnt16, 0);
    chk("rst_err", err16, 0);

    // Release: INIT while the synchronisers fill, then LOW.
    reset_n = 1;
    step(); chk("init1", st16, 0);
    step(); chk("init2", st16, 0);
    step(); chk("init_to_low", st16, 1);

    // One full cycle, then 255 more to wrap the 8-bit counter.
    handshake();
    chk("one_cycle_cnt", cnt16, 1);
    chk("one_cycle_state", st16, 1);
    for (int i = 0; i < 255; i++) handshake();
    chk("wrap_cnt", cnt16, 0);
    chk("wrap_cnt0", cnt0, 0);

    // Spurious c rise in LOW.
    a = 1; b = 0; c = 1; steps(4);
    chk("spur_err", err16, 1);
    chk("spur_code", code16, 1);
    chk("spur_state", st16, 5);
    c = 0; steps(2); c = 1; steps(3);
    chk("spur_sticky_code", code16, 1);
    clr = 1; step(); clr = 0;
    chk("clr_to_high", st16, 3);
    chk("clr_err", err16, 0);
    a = 0; c = 0; steps(4);

    // Timeout: a=b=1, c stays low for 20 clocks.
    a = 1; b = 1; armed_n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (st16 == 3'd2) armed_n++;
    end
    chk("armed_cycles", armed_n, 16);
    chk("tmo_state", st16, 5);
    chk("tmo_code", code16, 2);
    chk("notmo_state", st0, 2);
    chk("notmo_err", err0, 0);
    a = 0; b = 0; steps(3);
    clr = 1; step(); clr = 0;
    chk("tmo_clear_state", st16, 1);
    steps(2);

    // Withdrawal before c rises.
    saved = m_cnt[0];
    a = 1; b = 1; steps(3);
    chk("wd_armed", st16, 2);
    a = 0; steps(3);
    chk("wd_low", st16, 1);
    chk("wd_err", err16, 0);
    chk("wd_cnt", cnt16, saved);

    // Reset pulse while in ARMED_LO.
    a = 1; b = 1; steps(3); c = 1; steps(3); a = 0; b = 0; steps(3);
    chk("armed_lo", st16, 4);
    reset_n = 0; c = 0; step(); reset_n = 1;
    chk("mid_rst_state", st16, 0);
    chk("mid_rst_cnt", cnt16, 0);
    steps(3);
    chk("mid_rst_low", st16, 1);

    // clear coinciding with a completing fall.
    handshake();
    chk("pre_clr_cnt", cnt16, 1);
    a = 1; b = 1; steps(3); c = 1; steps(3); a = 0; b = 0; steps(3);
    c = 0;
    for (int i = 0; i < 6; i++) begin
      clr = (m_st[0] == 4 && hist[$][0] == 1'b0);
      step();
      clr = 0;
    end
    chk("clr_fall_cnt", cnt16, 0);
    chk("clr_fall_state", st16, 1);

    // Random traffic including clears and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) a = 1'($urandom);
      if ($urandom_range(3) == 0) b = 1'($urandom);
      if ($urandom_range(3) == 0) c = 1'($urandom);
      clr     = ($urandom_range(19) == 0);
      reset_n = ($urandom_range(99) != 0);
      step();
    end
    reset_n = 1; clr = 0;
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
